lfsr_seq_ctrl: RTL and testbench
================================

# lfsr_seq_ctrl

Sequencer and two-way arbiter for the shared 26-bit LFSR (`load`/`din`/`q` interface; free-running shift, `load` has priority). Grants the LFSR to one of two requesters round-robin, loads the winner's seed, forwards a requested number of consecutive LFSR states as a valid-qualified stream tagged with the owner, then releases the LFSR. Sits between the LFSR instance and its consumers, such as the scrambler and test-pattern generator.

## Interface
- `WIDTH`, 26: LFSR state width; all state buses are `[1:WIDTH]`.
- `LEN_W`, 8: width of the per-request word count.
- `clk` in 1: the only clock; everything is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 2: request per requester; level, held until `ack`.
- `seed0`, `seed1` in WIDTH: seed per requester; sampled in the grant cycle.
- `len0`, `len1` in LEN_W: number of output words per requester; sampled in the grant cycle.
- `ack` in/out: out 2; one-hot, one-cycle pulse; the request was captured.
- `lfsr_load` out 1: drives the LFSR `load` input.
- `lfsr_din` out WIDTH: drives the LFSR `din` input.
- `lfsr_q` in WIDTH: LFSR `q` output.
- `out_valid` out 1: `out_data` is valid this cycle.
- `out_data` out WIDTH: LFSR state forwarded to the consumer.
- `out_id` out 1: owner of the current session (0 or 1).
- `out_last` out 1: final word of the session; qualified by `out_valid`.
- `busy` out 1: a session is in progress (state is not IDLE).

## Operation
- FSM states: IDLE, LOAD, RUN.
- **IDLE**
  - If any `req` bit is set, select one requester:
    - Both requesting: the one matching round-robin pointer `rr`.
    - Otherwise: the single requester.
  - Capture its seed into `seed_r`, its len into `cnt`, and its index into `id_r`.
  - Pulse `ack[id]` on the next cycle. The requester may drop `req` after `ack`.
- **Zero-length request**
  - Captured len == 0: ack as normal, stay in IDLE.
  - No load and no output are produced.
  - `rr` still advances.
- **Zero seed**
  - Captured seed == 0 would lock the LFSR.
  - Substitute seed with bit 26 = 1 and all other bits 0.
- **Transitions**
  - IDLE -> LOAD on capture with len != 0. `rr` becomes the other requester.
  - LOAD lasts exactly 1 cycle.
    - `lfsr_load` = 1 and `lfsr_din` = `seed_r`.
    - Next state is RUN.
  - In RUN: `out_valid` = 1, `out_data` = `lfsr_q`, `out_id` = `id_r`, and `cnt` decrements.
    - `out_last` = 1 when `cnt` == 1.
    - RUN -> IDLE after the last word.
- **Outputs outside sessions**
  - `lfsr_load` = 0 outside LOAD.
  - `lfsr_din` = 0 outside LOAD.
  - `out_*` = 0 outside RUN.
- **Reset** (any state, including mid-session)
  - State goes to IDLE and `rr` = 0.
  - `cnt`, `seed_r`, `id_r` = 0.
  - All outputs are 0 on the cycle after the `rst` edge.
  - An aborted session produces no `out_last`.
  - `req` is ignored while `rst` = 1.

## Timing
- All outputs are derived from registered state. No combinational path runs from `req`/`seed`/`len` to any output.
- Cycle t: IDLE samples `req`.
- Cycle t+1: state LOAD, `ack` pulse, `lfsr_load` = 1.
- Cycle t+2: first `out_valid`; `out_data` equals the seed (loaded value).
- Cycle t+1+N: `out_last`.
- Cycle t+2+N: IDLE again; earliest next capture.
- Each session costs N+2 cycles. The output words are consecutive LFSR states with no gaps.
- The LFSR shifts every non-load cycle. Its contents outside sessions are don't-care.
- Maximum len is 2^LEN_W − 1 = 255 words. There is no wrap of `cnt`.
- `busy` = 1 in LOAD and RUN; 0 in IDLE.

## Test plan
- **Reset**: `rst` = 1 for 2 cycles with `req` = 2'b11.
  - `ack`, `lfsr_load`, `out_valid`, and `busy` stay 0.
  - After release, requester 0 is granted first.
- **Single session**: `req` = 01, `seed0` = 26'b1_1010, `len0` = 4.
  - `ack` = 01 at t+1; `lfsr_load` = 1 with `din` = 1_1010 at t+1.
  - Four valid words: the first equals 1_1010, and each equals the LFSR model's next state.
  - `out_last` on the 4th word; `busy` drops at t+6.
- **Contention**: `req` = 11 held continuously, `len0` = 2, `len1` = 3.
  - Grants alternate 0, 1, 0.
  - `out_id` matches the grant, with 1 idle cycle between sessions.
- **Zero length / zero seed**:
  - `len1` = 0: `ack` = 10 with no load and no valid; the next grant goes to requester 0.
  - `seed0` = 0, `len0` = 1: `din` is bit 26 = 1 only.
- **Mid-session reset**: `len0` = 200; assert `rst` after 50 words.
  - The next cycle has all outputs 0, with no `out_last`.
  - A new request after release is served normally.
- **Maximum length**: `len0` = 255.
  - Exactly 255 valid words; `out_last` only on word 255.

Source files
------------

// File: rtl/lfsr_seq_ctrl_if.sv
// Bundle between the LFSR sequencer, its two requesters, the shared LFSR and the
// consumer stream. slave = the sequencer, master = everything around it.
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 26,
  parameter int LEN_W = 8
);
  logic [1:0]       req;
  logic [1:WIDTH]   seed0, seed1;
  logic [LEN_W-1:0] len0, len1;
  logic [1:0]       ack;
  logic             lfsr_load;
  logic [1:WIDTH]   lfsr_din;
  logic [1:WIDTH]   lfsr_q;
  logic             out_valid;
  logic [1:WIDTH]   out_data;
  logic             out_id;
  logic             out_last;
  logic             busy;

  modport slave (
    input  req, seed0, seed1, len0, len1, lfsr_q,
    output ack, lfsr_load, lfsr_din, out_valid, out_data, out_id, out_last, busy
  );

  modport master (
    output req, seed0, seed1, len0, len1, lfsr_q,
    input  ack, lfsr_load, lfsr_din, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Round-robin owner of a shared LFSR: loads the winner's seed, then streams N
// consecutive LFSR states tagged with the owner id.
module lfsr_seq_ctrl #(
  parameter int WIDTH = 26,
  parameter int LEN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  lfsr_seq_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  // An all-zero seed would lock the LFSR; bit WIDTH is the rightmost bit.
  localparam logic [1:WIDTH] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:WIDTH]   seed_q, seed_d;
  logic [1:0]       ack_q, ack_d;

  logic             sel;
  logic [1:WIDTH]   sel_seed;
  logic [LEN_W-1:0] sel_len;

  assign sel      = (bus.req == 2'b11) ? rr_q : bus.req[1];
  assign sel_seed = sel ? bus.seed1 : bus.seed0;
  assign sel_len  = sel ? bus.len1  : bus.len0;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    ack_d   = 2'b00;
    case (state_q)
      IDLE: begin
        // The ack cycle is skipped so a still-high req is not captured twice.
        if (bus.req != 2'b00 && ack_q == 2'b00) begin
          seed_d = (sel_seed == '0) ? SEED_ONE : sel_seed;
          cnt_d  = sel_len;
          id_d   = sel;
          ack_d  = sel ? 2'b10 : 2'b01;
          rr_d   = ~sel;
          if (sel_len != '0) state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      seed_q  <= '0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      ack_q   <= ack_d;
    end
  end

  logic in_load, in_run;
  assign in_load = (state_q == LOAD);
  assign in_run  = (state_q == RUN);

  assign bus.ack       = ack_q;
  assign bus.lfsr_load = in_load;
  assign bus.lfsr_din  = in_load ? seed_q : '0;
  assign bus.out_valid = in_run;
  assign bus.out_data  = in_run ? bus.lfsr_q : '0;
  assign bus.out_id    = in_run & id_q;
  assign bus.out_last  = in_run && (cnt_q == LEN_W'(1));
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench: drives lfsr_seq_ctrl next to a behavioural 26-bit LFSR and
// checks grants, loads and the forwarded stream against hand-derived values.
module tb_lfsr_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl_if #(.WIDTH(26), .LEN_W(8)) bus ();

  lfsr_seq_ctrl #(.WIDTH(26), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [1:26] nxt(input logic [1:26] s);
    nxt = {s[26] ^ s[6] ^ s[2] ^ s[1], s[1:25]};
  endfunction

  // Shared LFSR: free-running, load has priority.
  logic [1:26] lfsr = 26'h3FFFFFF;
  always @(posedge clk) lfsr <= bus.lfsr_load ? bus.lfsr_din : nxt(lfsr);
  assign bus.lfsr_q = lfsr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the IDLE cycle that captures; returns in the IDLE cycle after the session.
  task automatic session(input logic id, input logic [1:26] seed, input int n);
    logic [1:26] e;
    tick();
    chk("ack", bus.ack, id ? 2'b10 : 2'b01);
    chk("lfsr_load", bus.lfsr_load, 1);
    chk("lfsr_din", bus.lfsr_din, seed);
    chk("busy_load", bus.busy, 1);
    chk("valid_in_load", bus.out_valid, 0);
    e = seed;
    for (int i = 1; i <= n; i++) begin
      tick();
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, e);
      chk("out_id", bus.out_id, id);
      chk("out_last", bus.out_last, (i == n));
      e = nxt(e);
    end
    tick();
    chk("busy_after", bus.busy, 0);
    chk("valid_after", bus.out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = 2'b11;
    bus.seed0 = 26'h0ABCDE;
    bus.seed1 = 26'h1234567;
    bus.len0  = 8'd2;
    bus.len1  = 8'd3;

    // reset with both requesting
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_ack", bus.ack, 2'b00);
      chk("rst_load", bus.lfsr_load, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
    end
    rst = 1'b0;

    // contention: 0 first after reset, then alternate
    session(1'b0, 26'h0ABCDE, 2);
    session(1'b1, 26'h1234567, 3);
    session(1'b0, 26'h0ABCDE, 2);
    bus.req = 2'b00;
    tick();

    // single session
    bus.req   = 2'b01;
    bus.seed0 = 26'h1A;
    bus.len0  = 8'd4;
    session(1'b0, 26'h1A, 4);
    bus.req = 2'b00;
    tick();

    // zero length on requester 1 (rr points at 1), then zero seed on requester 0
    bus.req   = 2'b11;
    bus.len1  = 8'd0;
    bus.seed0 = 26'h0;
    bus.len0  = 8'd1;
    tick();
    chk("zl_ack", bus.ack, 2'b10);
    chk("zl_load", bus.lfsr_load, 0);
    chk("zl_valid", bus.out_valid, 0);
    chk("zl_busy", bus.busy, 0);
    tick();
    chk("zl_ack_gone", bus.ack, 2'b00);
    chk("zl_idle", bus.busy, 0);
    session(1'b0, 26'h1, 1);
    bus.req = 2'b00;
    tick();

    // mid-session reset after 50 words
    bus.req   = 2'b01;
    bus.seed0 = 26'h2AAAAAA;
    bus.len0  = 8'd200;
    begin
      logic [1:26] e;
      tick();
      chk("mr_ack", bus.ack, 2'b01);
      chk("mr_din", bus.lfsr_din, 26'h2AAAAAA);
      bus.req = 2'b00;
      e = 26'h2AAAAAA;
      for (int i = 1; i <= 50; i++) begin
        tick();
        chk("mr_valid", bus.out_valid, 1);
        chk("mr_data", bus.out_data, e);
        chk("mr_last", bus.out_last, 0);
        e = nxt(e);
      end
    end
    rst = 1'b1;
    tick();
    chk("mr_ack0", bus.ack, 2'b00);
    chk("mr_load0", bus.lfsr_load, 0);
    chk("mr_din0", bus.lfsr_din, 26'h0);
    chk("mr_valid0", bus.out_valid, 0);
    chk("mr_data0", bus.out_data, 26'h0);
    chk("mr_id0", bus.out_id, 0);
    chk("mr_last0", bus.out_last, 0);
    chk("mr_busy0", bus.busy, 0);
    rst = 1'b0;
    tick();
    chk("mr_idle", bus.busy, 0);
    bus.req   = 2'b10;
    bus.seed1 = 26'h155;
    bus.len1  = 8'd3;
    session(1'b1, 26'h155, 3);
    bus.req = 2'b00;
    tick();

    // maximum length
    bus.req   = 2'b01;
    bus.seed0 = 26'h3FFFFFF;
    bus.len0  = 8'd255;
    session(1'b0, 26'h3FFFFFF, 255);
    bus.req = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
